// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: receive side of the VGA character generator.
// Samples the generator's RGB/sync outputs, recovers pixel phase from hsync,
// checks line and frame lengths, and emits a coordinate-tagged pixel stream
// once the incoming timing has been seen clean for a whole frame.
module vga_rx_decoder #(
  parameter int unsigned CLK_FACTOR_25M = 4,
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned H_FP           = 16,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BP           = 48,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned V_FP           = 10,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BP           = 33,
  parameter bit          HS_ACTIVE_LOW  = 1'b1,
  parameter bit          VS_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic [3:0]  vga_r_i,
  input  logic [3:0]  vga_g_i,
  input  logic [3:0]  vga_b_i,
  input  logic        vga_hs_i,
  input  logic        vga_vs_i,
  output logic        pix_valid_o,
  output logic [9:0]  pix_x_o,
  output logic [9:0]  pix_y_o,
  output logic [11:0] pix_rgb_o,
  output logic        frame_start_o,
  output logic        line_err_o,
  output logic        frame_err_o,
  output logic        locked_o
);

  localparam int unsigned DW = $clog2(CLK_FACTOR_25M);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_FACTOR_25M - 1);
  localparam logic [DW-1:0] DIV_MID = DW'(CLK_FACTOR_25M / 2);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);

  // Line/frame counters saturate instead of wrapping so a stuck sync never
  // aliases back onto a valid length.
  localparam int unsigned CW = 12;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] H_TOTAL = CW'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_START = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_END   = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_TOTAL = CW'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_START = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_END   = CW'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  logic [3:0]    r_q, g_q, b_q;
  logic          hs_q, vs_q;
  logic          hs_prev;
  logic          vs_at_hs;
  logic          seen_hs, seen_vs;
  logic [DW-1:0] div_q;
  logic [CW-1:0] h_cnt, v_cnt;
  state_t        state;
  logic          acq_err;

  logic hs_edge, vs_edge, strobe, line_err, frame_err, any_err, pix_hit;

  // Input register; syncs are normalised to active-high here.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    if (!arstn_i) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      r_q  <= vga_r_i;
      g_q  <= vga_g_i;
      b_q  <= vga_b_i;
      hs_q <= vga_hs_i ^ HS_ACTIVE_LOW;
      vs_q <= vga_vs_i ^ VS_ACTIVE_LOW;
    end
  end

  // Sync edges, mid-pixel strobe and the line/frame length checks.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    hs_edge   = 1'b0;
    vs_edge   = 1'b0;
    strobe    = 1'b0;
    line_err  = 1'b0;
    frame_err = 1'b0;
    pix_hit   = 1'b0;
    hs_edge   = hs_q & ~hs_prev;
    vs_edge   = hs_edge & vs_q & ~vs_at_hs;
    // An hsync edge realigns the pixel phase, so it suppresses any strobe.
    strobe    = ~hs_edge & (div_q == DIV_MID);
    line_err  = hs_edge & seen_hs & (h_cnt != H_TOTAL);
    frame_err = vs_edge & seen_vs & ((v_cnt + CW'(1)) != V_TOTAL);
    pix_hit   = strobe && (state == LOCKED) &&
                (h_cnt >= H_START) && (h_cnt < H_END) &&
                (v_cnt >= V_START) && (v_cnt < V_END);
  end

  assign any_err = line_err | frame_err;

  // Pixel phase divider plus horizontal and vertical position counters.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      hs_prev  <= 1'b0;
      vs_at_hs <= 1'b0;
      seen_hs  <= 1'b0;
      seen_vs  <= 1'b0;
      div_q    <= '0;
      h_cnt    <= '0;
      v_cnt    <= '0;
    end else begin
      hs_prev <= hs_q;
      if (hs_edge) begin
        // The edge cycle itself is phase 0 of pixel 0, so the divider
        // carries on from 1 and the strobe lands mid-pixel for any factor.
        div_q    <= DIV_ONE;
        h_cnt    <= '0;
        seen_hs  <= 1'b1;
        vs_at_hs <= vs_q;
        if (vs_edge) begin
          v_cnt   <= '0;
          seen_vs <= 1'b1;
        end else if (v_cnt != CNT_MAX) begin
          v_cnt <= v_cnt + CW'(1);
        end
      end else begin
        div_q <= (div_q == DIV_MAX) ? '0 : div_q + DIV_ONE;
        if (strobe && (h_cnt != CNT_MAX)) begin
          h_cnt <= h_cnt + CW'(1);
        end
      end
    end
  end

  // Registered pixel stream and error pulses; coordinates hold between pixels.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pix_valid_o   <= 1'b0;
      pix_x_o       <= '0;
      pix_y_o       <= '0;
      pix_rgb_o     <= '0;
      frame_start_o <= 1'b0;
      line_err_o    <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      pix_valid_o   <= pix_hit;
      frame_start_o <= pix_hit && (h_cnt == H_START) && (v_cnt == V_START);
      line_err_o    <= line_err;
      frame_err_o   <= frame_err;
      if (pix_hit) begin
        pix_x_o   <= 10'(h_cnt - H_START);
        pix_y_o   <= 10'(v_cnt - V_START);
        pix_rgb_o <= {r_q, g_q, b_q};
      end
    end
  end

  // Lock FSM: one clean vs-to-vs frame in ACQUIRE earns LOCKED; any error drops it.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state    <= UNLOCKED;
      acq_err  <= 1'b0;
      locked_o <= 1'b0;
    end else begin
      case (state)
        UNLOCKED: begin
          if (vs_edge) begin
            state   <= ACQUIRE;
            acq_err <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (vs_edge) begin
            if (acq_err || any_err) begin
              acq_err <= 1'b0;
            end else begin
              state    <= LOCKED;
              locked_o <= 1'b1;
            end
          end else if (any_err) begin
            acq_err <= 1'b1;
          end
        end
        LOCKED: begin
          if (any_err) begin
            state    <= UNLOCKED;
            locked_o <= 1'b0;
          end
        end
        default: begin
          state    <= UNLOCKED;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder: a small-timing VGA generator drives the decoder;
// expected pixels are queued as they are driven and a monitor pops them
// whenever the decoder presents pix_valid_o.
module tb_vga_rx_decoder;

  localparam int CF       = 4;
  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOT    = H_SYNC + H_BP + H_ACTIVE + H_FP;  // 16
  localparam int V_TOT    = V_SYNC + V_BP + V_ACTIVE + V_FP;  // 11
  localparam int HS0      = H_SYNC + H_BP;                    // 6
  localparam int VS0      = V_SYNC + V_BP;                    // 4
  localparam int RST_PX   = 4;                                // back porch column

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic [3:0]  vga_r_i, vga_g_i, vga_b_i;
  logic        vga_hs_i, vga_vs_i;
  logic        pix_valid_o;
  logic [9:0]  pix_x_o, pix_y_o;
  logic [11:0] pix_rgb_o;
  logic        frame_start_o, line_err_o, frame_err_o, locked_o;

  vga_rx_decoder #(
    .CLK_FACTOR_25M (CF),
    .H_ACTIVE       (H_ACTIVE),
    .H_FP           (H_FP),
    .H_SYNC         (H_SYNC),
    .H_BP           (H_BP),
    .V_ACTIVE       (V_ACTIVE),
    .V_FP           (V_FP),
    .V_SYNC         (V_SYNC),
    .V_BP           (V_BP),
    .HS_ACTIVE_LOW  (1'b1),
    .VS_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .vga_r_i       (vga_r_i),
    .vga_g_i       (vga_g_i),
    .vga_b_i       (vga_b_i),
    .vga_hs_i      (vga_hs_i),
    .vga_vs_i      (vga_vs_i),
    .pix_valid_o   (pix_valid_o),
    .pix_x_o       (pix_x_o),
    .pix_y_o       (pix_y_o),
    .pix_rgb_o     (pix_rgb_o),
    .frame_start_o (frame_start_o),
    .line_err_o    (line_err_o),
    .frame_err_o   (frame_err_o),
    .locked_o      (locked_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int x;
    int y;
    int rgb;
    int fs;
  } px_t;

  px_t exp_q[$];
  int  n_checks   = 0;
  int  n_err      = 0;
  int  n_pix      = 0;
  int  n_line_err = 0;
  int  n_frm_err  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero();
    check("rst_pix_xy", 32'({pix_valid_o, pix_x_o, pix_y_o}), 32'd0);
    check("rst_rgb_flags", 32'({pix_rgb_o, frame_start_o, line_err_o, frame_err_o, locked_o}), 32'd0);
  endtask

  // Monitor: counts error pulses and scores every presented pixel.
  always @(negedge clk_i) begin
    px_t e;
    if (line_err_o)  n_line_err++;
    if (frame_err_o) n_frm_err++;
    if (pix_valid_o) begin
      n_pix++;
      if (exp_q.size() == 0) begin
        check("pix_queue_depth", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("pix_x", 32'(pix_x_o), e.x);
        check("pix_y", 32'(pix_y_o), e.y);
        check("pix_rgb", 32'(pix_rgb_o), e.rgb);
        check("frame_start", 32'(frame_start_o), e.fs);
      end
    end
  end

  task automatic reset_pulse();
    arstn_i = 1'b0;
    #1;
    check_outputs_zero();
    repeat (3) @(negedge clk_i);
    arstn_i = 1'b1;
  endtask

  // Drive one frame starting at a falling clock edge. long_line gets one extra
  // front-porch pixel; pixels on lines below exp_lim are expected at the output;
  // rst_line pulses reset in the back porch of that line.
  task automatic drive_frame(input int nlines, input int long_line, input int exp_lim,
                             input int rst_line, output int pushed);
    int  len, x, y, rgb;
    bit  act;
    px_t e;
    pushed = 0;
    for (int v = 0; v < nlines; v++) begin
      len = (v == long_line) ? H_TOT + 1 : H_TOT;
      for (int p = 0; p < len; p++) begin
        if (v == rst_line && p == RST_PX) reset_pulse();
        act = (p >= HS0) && (p < HS0 + H_ACTIVE) && (v >= VS0) && (v < VS0 + V_ACTIVE);
        x   = p - HS0;
        y   = v - VS0;
        rgb = ((x & 15) << 8) | ((y & 15) << 4) | ((x >> 4) & 15);
        vga_hs_i = (p < H_SYNC) ? 1'b0 : 1'b1;
        vga_vs_i = (v < V_SYNC) ? 1'b0 : 1'b1;
        {vga_r_i, vga_g_i, vga_b_i} = act ? 12'(rgb) : 12'd0;
        if (act && v < exp_lim) begin
          e.x = x; e.y = y; e.rgb = rgb; e.fs = (x == 0 && y == 0) ? 1 : 0;
          exp_q.push_back(e);
          pushed++;
        end
        repeat (CF) @(negedge clk_i);
      end
    end
  endtask

  initial begin
    int pushed;
    arstn_i  = 1'b0;
    vga_r_i  = '0; vga_g_i = '0; vga_b_i = '0;
    vga_hs_i = 1'b1; vga_vs_i = 1'b1;

    // Reset held with toggling inputs: everything stays at zero.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      {vga_r_i, vga_g_i, vga_b_i, vga_hs_i, vga_vs_i} = 14'($urandom);
      if (i % 2 == 1) check_outputs_zero();
    end
    @(negedge clk_i);
    {vga_r_i, vga_g_i, vga_b_i} = '0;
    vga_hs_i = 1'b1; vga_vs_i = 1'b1;
    @(negedge clk_i);
    arstn_i = 1'b1;
    repeat (3) @(negedge clk_i);

    // Nominal frames: lock at the second vs edge, then full frames of pixels.
    drive_frame(V_TOT, -1, 0, -1, pushed);
    check("locked_after_acquire_frame", 32'(locked_o), 32'd0);
    n_pix = 0;
    drive_frame(V_TOT, -1, V_TOT, -1, pushed);
    check("locked_frame2", 32'(locked_o), 32'd1);
    check("frame2_pix_count", n_pix, H_ACTIVE * V_ACTIVE);
    n_pix = 0;
    drive_frame(V_TOT, -1, V_TOT, -1, pushed);
    check("frame3_pix_count", n_pix, H_ACTIVE * V_ACTIVE);
    check("nominal_line_errs", n_line_err, 0);
    check("nominal_frame_errs", n_frm_err, 0);

    // One 17-pixel line: single line error, pixels stop, relock two frames later.
    n_pix = 0;
    drive_frame(V_TOT, VS0 + 1, VS0 + 2, -1, pushed);
    check("stretch_pix_count", n_pix, pushed);
    check("locked_after_stretch", 32'(locked_o), 32'd0);
    drive_frame(V_TOT, -1, 0, -1, pushed);
    check("locked_reacquire", 32'(locked_o), 32'd0);
    check("stretch_line_errs", n_line_err, 1);
    check("stretch_frame_errs", n_frm_err, 0);
    n_pix = 0;
    drive_frame(V_TOT, -1, V_TOT, -1, pushed);
    check("relock_after_stretch", 32'(locked_o), 32'd1);
    check("relock_pix_count", n_pix, H_ACTIVE * V_ACTIVE);

    // Short frame (one line missing): frame error at the next vs edge.
    drive_frame(V_TOT - 1, -1, V_TOT, -1, pushed);
    check("locked_during_short", 32'(locked_o), 32'd1);
    check("short_no_err_yet", n_frm_err, 0);
    drive_frame(V_TOT, -1, 0, -1, pushed);
    check("short_frame_errs", n_frm_err, 1);
    check("locked_after_short", 32'(locked_o), 32'd0);
    drive_frame(V_TOT, -1, 0, -1, pushed);
    check("locked_acquire_short", 32'(locked_o), 32'd0);
    drive_frame(V_TOT, -1, V_TOT, -1, pushed);
    check("relock_after_short", 32'(locked_o), 32'd1);

    // Reset mid-frame: outputs clear, two vs edges to relock.
    drive_frame(V_TOT, -1, VS0 + 2, VS0 + 2, pushed);
    check("locked_after_reset", 32'(locked_o), 32'd0);
    drive_frame(V_TOT, -1, 0, -1, pushed);
    check("locked_acquire_reset", 32'(locked_o), 32'd0);
    n_pix = 0;
    drive_frame(V_TOT, -1, V_TOT, -1, pushed);
    check("relock_after_reset", 32'(locked_o), 32'd1);
    check("reset_relock_pix_count", n_pix, H_ACTIVE * V_ACTIVE);

    repeat (10) @(negedge clk_i);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("total_line_errs", n_line_err, 1);
    check("total_frame_errs", n_frm_err, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
